// File: rtl/pr_bus_arbiter_if.sv
// Two-master request/ack handshake plus the Pr peripheral bus, as seen by pr_bus_arbiter.
`timescale 1ns/1ps
interface pr_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic [31:0] m0_rd;
    logic        m0_ack;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic [31:0] m1_rd;
    logic        m1_ack;
    logic        m1_err;

    logic        PrStb;
    logic        PrWe;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        PrAck;
    logic [1:0]  grant;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_rd, m0_ack, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wd,
        output m1_rd, m1_ack, m1_err,
        output PrStb, PrWe, PrAddr, PrWD, grant,
        input  PrRD, PrAck
    );

    // Requesters and bus slave side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_rd, m0_ack, m0_err,
        output m1_req, m1_we, m1_addr, m1_wd,
        input  m1_rd, m1_ack, m1_err,
        input  PrStb, PrWe, PrAddr, PrWD, grant,
        output PrRD, PrAck
    );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the Pr peripheral bus, with
// late-ack hold and timeout abort.
`timescale 1ns/1ps
module pr_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    pr_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_m1;
    logic       owner_m1;
    logic [7:0] cnt;
    logic       pick_m1;
    logic       finish;
    logic [31:0] done_rd;

    // m1 wins when it is the only requester, or on contention when m0 went last
    always_comb begin
        pick_m1 = bus.m1_req && (!bus.m0_req || !last_m1);
        finish  = bus.PrAck || (cnt == CNT_LAST);
        done_rd = bus.PrAck ? bus.PrRD : '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_m1    <= 1'b1;
            owner_m1   <= 1'b0;
            cnt        <= '0;
            bus.PrStb  <= 1'b0;
            bus.PrWe   <= 1'b0;
            bus.PrAddr <= '0;
            bus.PrWD   <= '0;
            bus.grant  <= '0;
            bus.m0_rd  <= '0;
            bus.m0_ack <= 1'b0;
            bus.m0_err <= 1'b0;
            bus.m1_rd  <= '0;
            bus.m1_ack <= 1'b0;
            bus.m1_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        owner_m1   <= pick_m1;
                        last_m1    <= pick_m1;
                        bus.grant  <= pick_m1 ? 2'b10 : 2'b01;
                        bus.PrStb  <= 1'b1;
                        bus.PrWe   <= pick_m1 ? bus.m1_we   : bus.m0_we;
                        bus.PrAddr <= pick_m1 ? bus.m1_addr : bus.m0_addr;
                        bus.PrWD   <= pick_m1 ? bus.m1_wd   : bus.m0_wd;
                        cnt        <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        if (owner_m1) begin
                            bus.m1_rd  <= done_rd;
                            bus.m1_err <= !bus.PrAck;
                            bus.m1_ack <= 1'b1;
                        end else begin
                            bus.m0_rd  <= done_rd;
                            bus.m0_err <= !bus.PrAck;
                            bus.m0_ack <= 1'b1;
                        end
                        bus.PrStb <= 1'b0;
                        bus.PrWe  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    bus.m0_ack <= 1'b0;
                    bus.m0_err <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.m1_err <= 1'b0;
                    bus.grant  <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
